// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for mem_arbiter: FSM states, requester indices and
// write-enable opcode values used by the arbiter and its picker.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_e;

  localparam int unsigned NUM_REQ = 2;

  localparam logic REQ_CORE   = 1'b0;
  localparam logic REQ_LOADER = 1'b1;

  localparam logic [3:0] WE_READ = 4'b0000;

  function automatic logic is_read(input logic [3:0] we);
    return (we == WE_READ);
  endfunction

endpackage

// File: rtl/mem_arbiter_rr2.sv
// Two-input picker returning a one-hot grant. ARB_ROUND_ROBIN_EN selects
// round-robin on contention; otherwise requester 0 has fixed priority.
module arb_rr2
  import mem_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic               last_gnt,
  output logic [NUM_REQ-1:0] gnt
);

`ifdef ARB_ROUND_ROBIN_EN
  always_comb begin
    gnt = '0;
    if (req[REQ_CORE] && req[REQ_LOADER]) begin
      // On contention the requester that was not served last goes next.
      if (last_gnt == REQ_CORE) begin
        gnt[REQ_LOADER] = 1'b1;
      end else begin
        gnt[REQ_CORE] = 1'b1;
      end
    end else begin
      gnt = req;
    end
  end
`else
  logic unused_last_gnt;
  assign unused_last_gnt = last_gnt;

  always_comb begin
    gnt             = '0;
    gnt[REQ_CORE]   = req[REQ_CORE];
    gnt[REQ_LOADER] = req[REQ_LOADER] & ~req[REQ_CORE];
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester single-port memory arbiter with lock/ownership FSM and a
// one-cycle read-return pipeline. Define ARB_ROUND_ROBIN_EN for round-robin.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int AWIDTH = 14,
  parameter int DWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              lock0,
  input  logic              lock1,
  input  logic [3:0]        we0,
  input  logic [3:0]        we1,
  input  logic [AWIDTH-1:0] addr0,
  input  logic [AWIDTH-1:0] addr1,
  input  logic [DWIDTH-1:0] wdata0,
  input  logic [DWIDTH-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DWIDTH-1:0] rdata0,
  output logic [DWIDTH-1:0] rdata1,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [DWIDTH-1:0] mem_din,
  input  logic [DWIDTH-1:0] mem_dout
);

  arb_state_e state_q, state_d;
  logic       last_gnt_q, last_gnt_d;
  logic       rvalid0_q, rvalid0_d;
  logic       rvalid1_q, rvalid1_d;

  logic       arb_open;
  logic [1:0] pick;

  arb_rr2 u_pick (
    .req      ({req1, req0}),
    .last_gnt (last_gnt_q),
    .gnt      (pick)
  );

  // A lock that drops this cycle reopens arbitration in the same cycle.
  always_comb begin
    arb_open = 1'b0;
    gnt0     = 1'b0;
    gnt1     = 1'b0;
    unique case (state_q)
      OWN0: begin
        arb_open = ~lock0;
        gnt0     = lock0 & req0;
      end
      OWN1: begin
        arb_open = ~lock1;
        gnt1     = lock1 & req1;
      end
      default: arb_open = 1'b1;
    endcase
    if (arb_open) begin
      gnt0 = pick[REQ_CORE];
      gnt1 = pick[REQ_LOADER];
    end
    if (!rst) begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    if (arb_open) begin
      state_d = IDLE;
      if (gnt0 && lock0) begin
        state_d = OWN0;
      end else if (gnt1 && lock1) begin
        state_d = OWN1;
      end
    end

    last_gnt_d = last_gnt_q;
    if (gnt1) begin
      last_gnt_d = REQ_LOADER;
    end else if (gnt0) begin
      last_gnt_d = REQ_CORE;
    end

    rvalid0_d = gnt0 & is_read(we0);
    rvalid1_d = gnt1 & is_read(we1);
  end

  always_comb begin
    mem_en   = gnt0 | gnt1;
    mem_we   = '0;
    mem_addr = '0;
    mem_din  = '0;
    if (gnt0) begin
      mem_we   = we0;
      mem_addr = addr0;
      mem_din  = wdata0;
    end else if (gnt1) begin
      mem_we   = we1;
      mem_addr = addr1;
      mem_din  = wdata1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      last_gnt_q <= REQ_LOADER;
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      rvalid0_q  <= rvalid0_d;
      rvalid1_q  <= rvalid1_d;
    end
  end

  // Memory data arrives the cycle after the grant, alongside the flopped valid.
  assign rvalid0 = rvalid0_q;
  assign rvalid1 = rvalid1_q;
  assign rdata0  = rvalid0_q ? mem_dout : '0;
  assign rdata1  = rvalid1_q ? mem_dout : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a behavioural one-cycle-latency memory.
module tb_mem_arbiter;

  localparam int AW = 14;
  localparam int DW = 32;

  logic          clk;
  logic          rst;
  logic          req0, req1, lock0, lock1;
  logic [3:0]    we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1;
  logic [DW-1:0] rdata0, rdata1;
  logic          mem_en;
  logic [3:0]    mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din, mem_dout;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp0_q[$];
  logic [DW-1:0] exp1_q[$];
  logic [3:0]    cont_pat;

  mem_arbiter #(.AWIDTH(AW), .DWIDTH(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .req0     (req0),
    .req1     (req1),
    .lock0    (lock0),
    .lock1    (lock1),
    .we0      (we0),
    .we1      (we1),
    .addr0    (addr0),
    .addr1    (addr1),
    .wdata0   (wdata0),
    .wdata1   (wdata1),
    .gnt0     (gnt0),
    .gnt1     (gnt1),
    .rvalid0  (rvalid0),
    .rvalid1  (rvalid1),
    .rdata0   (rdata0),
    .rdata1   (rdata1),
    .mem_en   (mem_en),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_din  (mem_din),
    .mem_dout (mem_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: byte-enabled write, read-first, one-cycle read latency.
  initial begin
    mem_dout = '0;
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    mem[14'h010] = 32'hDEADBEEF;
    mem[14'h011] = 32'hCAFEF00D;
    mem[14'h030] = 32'h11223344;
    forever begin
      @(posedge clk);
      if (mem_en) begin
        mem_dout <= mem[mem_addr];
        for (int b = 0; b < 4; b++) begin
          if (mem_we[b]) mem[mem_addr][b*8 +: 8] <= mem_din[b*8 +: 8];
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (rvalid0) begin
        if (exp0_q.size() == 0) checkOutput("rvalid0 unexpected", 64'(rvalid0), 64'd0);
        else checkOutput("rdata0", 64'(rdata0), 64'(exp0_q.pop_front()));
      end else begin
        checkOutput("rdata0 zero when idle", 64'(rdata0), 64'd0);
      end
      if (rvalid1) begin
        if (exp1_q.size() == 0) checkOutput("rvalid1 unexpected", 64'(rvalid1), 64'd0);
        else checkOutput("rdata1", 64'(rdata1), 64'(exp1_q.pop_front()));
      end else begin
        checkOutput("rdata1 zero when idle", 64'(rdata1), 64'd0);
      end
    end
  end

  task automatic clearInputs();
    req0 = 0; req1 = 0; lock0 = 0; lock1 = 0;
    we0 = '0; we1 = '0; addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
  endtask

  task automatic applyStimulus(input string name,
                               input logic r0, input logic l0, input logic [3:0] w0,
                               input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                               input logic r1, input logic l1, input logic [3:0] w1,
                               input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                               input logic eg0, input logic eg1);
    logic [3:0] ewe;
    @(posedge clk);
    #1;
    req0 = r0; lock0 = l0; we0 = w0; addr0 = a0; wdata0 = d0;
    req1 = r1; lock1 = l1; we1 = w1; addr1 = a1; wdata1 = d1;
    #2;
    ewe = eg0 ? w0 : (eg1 ? w1 : 4'b0000);
    checkOutput({name, " gnt"}, 64'({gnt0, gnt1}), 64'({eg0, eg1}));
    checkOutput({name, " mem_en"}, 64'(mem_en), 64'(eg0 | eg1));
    checkOutput({name, " mem_we"}, 64'(mem_we), 64'(ewe));
    if (eg0) checkOutput({name, " mem_addr"}, 64'(mem_addr), 64'(a0));
    if (eg1) checkOutput({name, " mem_addr"}, 64'(mem_addr), 64'(a1));
  endtask

  task automatic resetDut();
    @(posedge clk);
    #1;
    rst = 0;
    req0 = 1; req1 = 1;
    #1;
    checkOutput("reset gnt", 64'({gnt0, gnt1}), 64'd0);
    checkOutput("reset mem_en", 64'(mem_en), 64'd0);
    checkOutput("reset mem_we", 64'(mem_we), 64'd0);
    checkOutput("reset rvalid", 64'({rvalid0, rvalid1}), 64'd0);
    checkOutput("reset rdata", 64'({rdata0, rdata1}), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    clearInputs();
    #2;
    rst = 1;
  endtask

  initial begin
    rst = 0;
    clearInputs();
    resetDut();

    // Single read
    exp0_q.push_back(32'hDEADBEEF);
    applyStimulus("single read", 1, 0, 4'h0, 14'h010, 0, 0, 0, 4'h0, 0, 0, 1, 0);
    applyStimulus("idle", 0, 0, 4'h0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0);

    // Contention right after reset
    resetDut();
`ifdef ARB_ROUND_ROBIN_EN
    cont_pat = 4'b1010;
`else
    cont_pat = 4'b0000;
`endif
    for (int i = 0; i < 4; i++) begin
      if (cont_pat[i]) exp1_q.push_back(32'hCAFEF00D);
      else exp0_q.push_back(32'hDEADBEEF);
      applyStimulus("contention", 1, 0, 4'h0, 14'h010, 0, 1, 0, 4'h0, 14'h011, 0,
                    ~cont_pat[i], cont_pat[i]);
    end
    applyStimulus("idle", 0, 0, 4'h0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0);

    // Locked write burst by requester 1 while requester 0 waits
    applyStimulus("burst w0", 0, 0, 4'h0, 14'h010, 0, 1, 1, 4'hF, 14'h020, 32'd1, 0, 1);
    applyStimulus("burst w1", 1, 0, 4'h0, 14'h010, 0, 1, 1, 4'hF, 14'h021, 32'd2, 0, 1);
    applyStimulus("burst w2", 1, 0, 4'h0, 14'h010, 0, 1, 1, 4'hF, 14'h022, 32'd3, 0, 1);
    exp0_q.push_back(32'hDEADBEEF);
    applyStimulus("unlock", 1, 0, 4'h0, 14'h010, 0, 0, 0, 4'h0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      exp1_q.push_back(32'(i + 1));
      applyStimulus("burst readback", 0, 0, 4'h0, 0, 0, 1, 0, 4'h0, 14'(14'h020 + i), 0, 0, 1);
    end

    // Lock held with no request: memory idles, other requester blocked
    exp0_q.push_back(32'hDEADBEEF);
    applyStimulus("lock0 grab", 1, 1, 4'h0, 14'h010, 0, 0, 0, 4'h0, 0, 0, 1, 0);
    applyStimulus("lock gap 1", 0, 1, 4'h0, 0, 0, 1, 0, 4'h0, 14'h011, 0, 0, 0);
    applyStimulus("lock gap 2", 0, 1, 4'h0, 0, 0, 1, 0, 4'h0, 14'h011, 0, 0, 0);
    exp1_q.push_back(32'hCAFEF00D);
    applyStimulus("lock release", 0, 0, 4'h0, 0, 0, 1, 0, 4'h0, 14'h011, 0, 0, 1);

    // Byte write then readback
    applyStimulus("byte write", 1, 0, 4'b0010, 14'h030, 32'h0000AB00, 0, 0, 4'h0, 0, 0, 1, 0);
    exp0_q.push_back(32'h1122AB44);
    applyStimulus("byte readback", 1, 0, 4'h0, 14'h030, 0, 0, 0, 4'h0, 0, 0, 1, 0);
    applyStimulus("idle", 0, 0, 4'h0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0);

    // Reset during a pending read return and an active lock
    applyStimulus("pre-reset read", 1, 1, 4'h0, 14'h010, 0, 0, 0, 4'h0, 0, 0, 1, 0);
    @(posedge clk);
    #1;
    rst = 0;
    clearInputs();
    #1;
    checkOutput("mid-read reset rvalid0", 64'(rvalid0), 64'd0);
    checkOutput("mid-read reset rdata0", 64'(rdata0), 64'd0);
    repeat (2) @(posedge clk);
    #3;
    rst = 1;
    exp1_q.push_back(32'hCAFEF00D);
    applyStimulus("post-reset idle arb", 0, 1, 4'h0, 0, 0, 1, 0, 4'h0, 14'h011, 0, 0, 1);
    applyStimulus("idle", 0, 0, 4'h0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0);
    applyStimulus("idle", 0, 0, 4'h0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0);
    @(posedge clk);
    #3;

    checkOutput("exp0 drained", 64'(exp0_q.size()), 64'd0);
    checkOutput("exp1 drained", 64'(exp1_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
